stall_replay: RTL and testbench
===============================

STALL_REPLAY -- requirements
Module: stall_replay

Interface
REQ-001 SHALL have parameter SIZE, default 5: replay FIFO depth in 16-bit entries, legal range 2..7.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1: branch/redirect flush; discards all buffered instructions.
REQ-005 SHALL have port stall, input, 1: decode cannot accept this cycle.
REQ-006 SHALL have port in_valid, input, 1: fetch presents an instruction.
REQ-007 SHALL have port in_instruction, input, 16: fetched instruction word.
REQ-008 SHALL have port fetch_hold, output, 1: fetch must not advance; present word ignored and held stable by fetch.
REQ-009 SHALL have port out_valid, output, 1: out_instruction is valid toward decode.
REQ-010 SHALL have port out_instruction, output, 16: instruction to decode.
REQ-011 SHALL have port count, output, 3: current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1: sticky protocol-violation flag.

Function
REQ-013 SHALL implement FSM states EMPTY (count=0), FILL (count>0, capturing under stall), DRAIN (count>0, replaying).
REQ-014 SHALL drive fetch_hold = (count!=0 && !stall) || count==SIZE, combinationally.
REQ-015 SHALL, when count=0, pass through combinationally: out_valid=in_valid, out_instruction=in_instruction.
REQ-016 SHALL, when count>0, drive out_valid=1 and out_instruction=FIFO head; in_instruction is not forwarded.
REQ-017 SHALL push in_instruction at tail when in_valid && !fetch_hold && stall (count=0 or FILL).
REQ-018 SHALL pop head when count>0 && !stall; push and pop are mutually exclusive by REQ-014.
REQ-019 SHALL transition EMPTY->FILL on push; FILL->DRAIN on the first pop cycle; DRAIN->FILL when stall=1 with count>0; DRAIN->EMPTY when the last entry pops.
REQ-020 SHALL keep pointers modulo SIZE; wrap from SIZE-1 to 0 with no bubble.
REQ-021 SHALL replay entries in exact push order, one per non-stalled cycle, zero latency from stall deassertion.
REQ-022 SHALL set overflow when in_valid && stall && count==SIZE; that word is dropped and overflow holds until reset.
REQ-023 SHALL give flush priority over push and pop: next cycle count=0, pointers=0, state=EMPTY; out_valid=0 during the flush cycle; overflow is unaffected.
REQ-024 SHALL ignore in_valid in any cycle where fetch_hold=1, regardless of stall.

Reset
REQ-025 SHALL on reset clear count, head, tail, overflow, and optional counter, and set state EMPTY.
REQ-026 SHALL have out_valid=in_valid and fetch_hold=0 in the cycle after reset, per REQ-014/015.
REQ-027 SHALL give reset priority over flush, push and pop; reset mid-DRAIN discards remaining entries.
REQ-028 SHALL leave FIFO storage contents uninitialised; they are never observable while count=0.

Configuration
REQ-029 SHALL, with macro STALL_REPLAY_STATS_EN defined, add output replay_count (16 bits): increments per pop, saturates at 0xFFFF, cleared by reset only, not by flush.
REQ-030 SHALL, without STALL_REPLAY_STATS_EN, omit the replay_count port and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover pass-through: stall=0, in 0x1111,0x2222 -> out_valid=1 with the same words in the same cycles; count stays 0.
REQ-032 SHALL cover capture/replay: stall=1 for 3 cycles, in 0xA001,0xA002,0xA003 -> count=3; stall=0 -> out 0xA001,0xA002,0xA003 on consecutive cycles, fetch_hold=1 for those cycles, then EMPTY.
REQ-033 SHALL cover full: stall=1 for 5 pushes -> count=5, fetch_hold=1; 6th word with in_valid -> overflow=1, word absent from replay.
REQ-034 SHALL cover wrap/restall: push 4, pop 3, restall and push 3 -> replay order remains correct across the pointer wrap.
REQ-035 SHALL cover flush mid-DRAIN: count=3, pop 1, flush -> out_valid=0 that cycle, then count=0 and in_instruction passes through next cycle.
REQ-036 SHALL cover reset mid-FILL with STALL_REPLAY_STATS_EN: replay_count=7, reset -> replay_count=0, count=0, overflow=0.

Source files
------------

// File: rtl/stall_replay_if.sv
// Fetch/decode handshake bundle for stall_replay; replay_count exists only
// when STALL_REPLAY_STATS_EN is defined.
interface stall_replay_if;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic [15:0] in_instruction;
  logic        fetch_hold;
  logic        out_valid;
  logic [15:0] out_instruction;
  logic [2:0]  count;
  logic        overflow;
`ifdef STALL_REPLAY_STATS_EN
  logic [15:0] replay_count;

  modport master (
    output flush, stall, in_valid, in_instruction,
    input  fetch_hold, out_valid, out_instruction, count, overflow, replay_count
  );
  modport slave (
    input  flush, stall, in_valid, in_instruction,
    output fetch_hold, out_valid, out_instruction, count, overflow, replay_count
  );
`else
  modport master (
    output flush, stall, in_valid, in_instruction,
    input  fetch_hold, out_valid, out_instruction, count, overflow
  );
  modport slave (
    input  flush, stall, in_valid, in_instruction,
    output fetch_hold, out_valid, out_instruction, count, overflow
  );
`endif
endinterface

// File: rtl/stall_replay.sv
// Captures fetched words while decode stalls and replays them in order once it resumes.
// Optional replay statistics counter enabled by defining STALL_REPLAY_STATS_EN.
module stall_replay #(
  parameter int SIZE = 5
) (
  input logic           clk,
  input logic           reset,
  stall_replay_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, FILL, DRAIN} state_e;

  localparam logic [2:0] SIZE_C = 3'(SIZE);
  localparam logic [2:0] LAST_C = 3'(SIZE - 1);

  state_e      state_q;
  logic [2:0]  count_q, count_d;
  logic [2:0]  head_q, head_d;
  logic [2:0]  tail_q, tail_d;
  logic        overflow_q, overflow_d;
  logic [15:0] mem_q [SIZE];

  logic empty, full, push, pop;

  assign empty = (count_q == 3'd0);
  assign full  = (count_q == SIZE_C);

  // Holding fetch while we replay or while full makes push and pop mutually exclusive.
  assign bus.fetch_hold = (!empty && !bus.stall) || full;
  assign push = bus.in_valid && !bus.fetch_hold && bus.stall && !bus.flush;
  assign pop  = !empty && !bus.stall && !bus.flush;

  assign bus.out_valid       = !bus.flush && (empty ? bus.in_valid : 1'b1);
  assign bus.out_instruction = empty ? bus.in_instruction : mem_q[head_q];
  assign bus.count           = count_q;
  assign bus.overflow        = overflow_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q | (bus.in_valid && bus.stall && full);
    if (bus.flush) begin
      count_d = 3'd0;
      head_d  = 3'd0;
      tail_d  = 3'd0;
    end else if (push) begin
      count_d = count_q + 3'd1;
      tail_d  = (tail_q == LAST_C) ? 3'd0 : tail_q + 3'd1;
    end else if (pop) begin
      count_d = count_q - 3'd1;
      head_d  = (head_q == LAST_C) ? 3'd0 : head_q + 3'd1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      count_q    <= 3'd0;
      head_q     <= 3'd0;
      tail_q     <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
      if (bus.flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: if (push) state_q <= FILL;
          FILL:  if (pop)  state_q <= (count_q == 3'd1) ? EMPTY : DRAIN;
          DRAIN: begin
            if (pop && count_q == 3'd1) state_q <= EMPTY;
            else if (bus.stall)         state_q <= FILL;
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  // NOTE: storage is deliberately not reset; entries are only visible while count > 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.in_instruction;
  end

`ifdef STALL_REPLAY_STATS_EN
  logic [15:0] replay_count_q;

  // Saturating pop counter; flush leaves it alone so statistics survive redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      replay_count_q <= 16'd0;
    end else if (pop && replay_count_q != 16'hFFFF) begin
      replay_count_q <= replay_count_q + 16'd1;
    end
  end

  assign bus.replay_count = replay_count_q;
`endif

endmodule

// File: tb/tb_stall_replay.sv
// Bench for stall_replay: directed scenarios plus randomized traffic checked
// against a queue-based model of the replay buffer.
module tb_stall_replay;

  localparam int SIZE = 5;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  stall_replay_if bus ();

  stall_replay #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words awaiting replay, sticky overflow, replay counter.
  logic [15:0] mq [$];
  bit          m_ovf;
  int          m_rc;

  function automatic bit m_hold();
    return (mq.size() != 0 && !bus.stall) || mq.size() == SIZE;
  endfunction

  function automatic bit m_out_valid();
    if (bus.flush) return 1'b0;
    return (mq.size() == 0) ? bus.in_valid : 1'b1;
  endfunction

  function automatic logic [15:0] m_out_word();
    return (mq.size() == 0) ? bus.in_instruction : mq[0];
  endfunction

  task automatic drive(input bit r, input bit f, input bit s, input bit v,
                       input logic [15:0] d);
    reset              = r;
    bus.flush          = f;
    bus.stall          = s;
    bus.in_valid       = v;
    bus.in_instruction = d;
    #1;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic step();
    bit h;
    h = m_hold();
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_rc  = 0;
    end else begin
      if (bus.in_valid && bus.stall && mq.size() == SIZE) m_ovf = 1'b1;
      if (bus.flush) begin
        mq.delete();
      end else if (!bus.stall && mq.size() != 0) begin
        void'(mq.pop_front());
        if (m_rc < 65535) m_rc++;
      end else if (bus.in_valid && bus.stall && !h) begin
        mq.push_back(bus.in_instruction);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 16'h0000);
    step();
    step();
    drive(0, 0, 0, 1, 16'h5A5A);
    tests++;
    if (bus.fetch_hold !== 1'b0) begin
      fails++; $display("FAIL reset_hold: got %b expected 0", bus.fetch_hold);
    end
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_instruction !== 16'h5A5A) begin
      fails++; $display("FAIL reset_pass: got %b/%h expected 1/5a5a", bus.out_valid, bus.out_instruction);
    end
    tests++;
    if (bus.count !== 3'd0 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL reset_state: count %0d ovf %b expected 0/0", bus.count, bus.overflow);
    end
    drive(0, 0, 0, 0, 16'h0000);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid);
    end
    step();
  endtask

  task automatic test_passthrough();
    logic [15:0] words [2];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, words[i]);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_instruction !== words[i]) begin
        fails++; $display("FAIL pass_word%0d: got %b/%h expected 1/%h", i, bus.out_valid, bus.out_instruction, words[i]);
      end
      step();
      tests++;
      if (bus.count !== 3'd0) begin
        fails++; $display("FAIL pass_count%0d: got %0d expected 0", i, bus.count);
      end
    end
  endtask

  task automatic test_capture_replay();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 16'hA001 + 16'(i));
      tests++;
      if (bus.fetch_hold !== 1'b0) begin
        fails++; $display("FAIL cap_hold%0d: got %b expected 0", i, bus.fetch_hold);
      end
      step();
    end
    tests++;
    if (bus.count !== 3'd3) begin
      fails++; $display("FAIL cap_count: got %0d expected 3", bus.count);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 16'hBEEF);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_instruction !== 16'hA001 + 16'(i) || bus.fetch_hold !== 1'b1) begin
        fails++; $display("FAIL replay%0d: got v%b %h h%b expected v1 %h h1", i, bus.out_valid, bus.out_instruction, bus.fetch_hold, 16'hA001 + 16'(i));
      end
      step();
    end
    drive(0, 0, 0, 1, 16'hBEEF);
    tests++;
    if (bus.count !== 3'd0 || bus.out_instruction !== 16'hBEEF || bus.fetch_hold !== 1'b0) begin
      fails++; $display("FAIL replay_empty: count %0d word %h hold %b expected 0 beef 0", bus.count, bus.out_instruction, bus.fetch_hold);
    end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < SIZE; i++) begin
      drive(0, 0, 1, 1, 16'hC000 + 16'(i));
      step();
    end
    drive(0, 0, 1, 1, 16'hC000 + 16'(SIZE));
    tests++;
    if (bus.count !== 3'(SIZE) || bus.fetch_hold !== 1'b1) begin
      fails++; $display("FAIL full_state: count %0d hold %b expected %0d 1", bus.count, bus.fetch_hold, SIZE);
    end
    step();
    tests++;
    if (bus.overflow !== 1'b1) begin
      fails++; $display("FAIL full_overflow: got %b expected 1", bus.overflow);
    end
    for (int i = 0; i < SIZE; i++) begin
      drive(0, 0, 0, 1, 16'h7777);
      tests++;
      if (bus.out_instruction !== 16'hC000 + 16'(i)) begin
        fails++; $display("FAIL full_replay%0d: got %h expected %h", i, bus.out_instruction, 16'hC000 + 16'(i));
      end
      step();
    end
    drive(0, 0, 0, 1, 16'h7777);
    tests++;
    if (bus.count !== 3'd0 || bus.out_instruction !== 16'h7777 || bus.overflow !== 1'b1) begin
      fails++; $display("FAIL full_dropped: count %0d word %h ovf %b expected 0 7777 1", bus.count, bus.out_instruction, bus.overflow);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_words [4];
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 16'hD000 + 16'(i));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 16'h0000);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 16'hE000 + 16'(i));
      step();
    end
    tests++;
    if (bus.count !== 3'd4) begin
      fails++; $display("FAIL wrap_count: got %0d expected 4", bus.count);
    end
    exp_words[0] = 16'hD003;
    exp_words[1] = 16'hE000;
    exp_words[2] = 16'hE001;
    exp_words[3] = 16'hE002;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 16'h0000);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_instruction !== exp_words[i]) begin
        fails++; $display("FAIL wrap_replay%0d: got %b/%h expected 1/%h", i, bus.out_valid, bus.out_instruction, exp_words[i]);
      end
      step();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 16'hF100 + 16'(i));
      step();
    end
    drive(0, 0, 0, 1, 16'h1234);
    step();
    drive(0, 1, 0, 1, 16'h1234);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid);
    end
    step();
    drive(0, 0, 0, 1, 16'hF0F0);
    tests++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b1 || bus.out_instruction !== 16'hF0F0) begin
      fails++; $display("FAIL flush_after: count %0d v%b %h expected 0 v1 f0f0", bus.count, bus.out_valid, bus.out_instruction);
    end
    step();
  endtask

  task automatic test_random();
    bit r, f, s, v;
    logic [15:0] d;
    s = 1'b0;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(99) == 0);
      f = ($urandom_range(24) == 0);
      if ($urandom_range(3) == 0) s = ~s;
      v = f ? 1'b0 : ($urandom_range(3) != 0);
      d = 16'($urandom);
      drive(r, f, s, v, d);
      tests++;
      if (bus.fetch_hold !== m_hold()) begin
        fails++; $display("FAIL rand_hold@%0d: got %b expected %b", n, bus.fetch_hold, m_hold());
      end
      tests++;
      if (bus.out_valid !== m_out_valid()) begin
        fails++; $display("FAIL rand_valid@%0d: got %b expected %b", n, bus.out_valid, m_out_valid());
      end
      if (m_out_valid()) begin
        tests++;
        if (bus.out_instruction !== m_out_word()) begin
          fails++; $display("FAIL rand_word@%0d: got %h expected %h", n, bus.out_instruction, m_out_word());
        end
      end
      tests++;
      if (bus.count !== 3'(mq.size()) || bus.overflow !== m_ovf) begin
        fails++; $display("FAIL rand_state@%0d: count %0d ovf %b expected %0d %b", n, bus.count, bus.overflow, mq.size(), m_ovf);
      end
`ifdef STALL_REPLAY_STATS_EN
      tests++;
      if (bus.replay_count !== 16'(m_rc)) begin
        fails++; $display("FAIL rand_replays@%0d: got %0d expected %0d", n, bus.replay_count, m_rc);
      end
`endif
      step();
    end
  endtask

`ifdef STALL_REPLAY_STATS_EN
  task automatic test_stats();
    drive(1, 0, 0, 0, 16'h0000);
    step();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 1, 16'h4000 + 16'(i)); step(); end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 16'h0000); step(); end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 1, 16'h4100 + 16'(i)); step(); end
    drive(0, 1, 0, 0, 16'h0000);
    step();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 1, 16'h4200 + 16'(i)); step(); end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 16'h0000); step(); end
    for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 1, 16'h4300 + 16'(i)); step(); end
    tests++;
    if (bus.replay_count !== 16'd7) begin
      fails++; $display("FAIL stats_count: got %0d expected 7", bus.replay_count);
    end
    drive(1, 0, 1, 1, 16'h4400);
    step();
    drive(0, 0, 0, 0, 16'h0000);
    tests++;
    if (bus.replay_count !== 16'd0 || bus.count !== 3'd0 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL stats_reset: rc %0d count %0d ovf %b expected 0 0 0", bus.replay_count, bus.count, bus.overflow);
    end
    step();
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    m_ovf = 1'b0;
    m_rc  = 0;
    test_reset();
    test_passthrough();
    test_capture_replay();
    test_full();
    test_wrap();
    test_flush();
    test_random();
`ifdef STALL_REPLAY_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
